// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one synchronous single-port memory between a VGA byte
//            reader and a CPU read/write port, with CPU starvation relief.
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [7:0]        vga_data,
    output logic              vga_valid,
    input  logic              cpu_req,
    input  logic              cpu_wren,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    localparam logic [7:0] c_STARVE_MAX = 8'(STARVE_LIMIT);

    logic [1:0] r_state;
    logic [7:0] r_starve;
    logic       r_owner_cpu;
    logic       r_is_write;
    logic [1:0] r_byte_sel;

    logic       w_any_req;
    logic       w_starved;
    logic       w_cpu_wins;
    logic [7:0] w_byte;

    assign w_any_req  = vga_req | cpu_req;
    assign w_starved  = (r_starve == c_STARVE_MAX);
    // VGA has priority unless the CPU has waited through the allowed run of VGA grants
    assign w_cpu_wins = cpu_req & (~vga_req | w_starved);

    always_comb begin
        w_byte = 8'h00;
        case (r_byte_sel)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_IDLE;
            r_starve    <= 8'd0;
            r_owner_cpu <= 1'b0;
            r_is_write  <= 1'b0;
            r_byte_sel  <= 2'd0;
            mem_addr    <= '0;
            mem_wren    <= 1'b0;
            mem_wdata   <= '0;
            cpu_rdata   <= '0;
            cpu_ready   <= 1'b0;
            vga_data    <= 8'h00;
            vga_valid   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (!cpu_req) begin
                        r_starve <= 8'd0;
                    end
                    if (w_any_req) begin
                        r_state     <= c_ISSUE;
                        r_owner_cpu <= w_cpu_wins;
                        r_byte_sel  <= vga_addr[1:0];
                        if (w_cpu_wins) begin
                            mem_addr   <= cpu_addr;
                            mem_wren   <= cpu_wren;
                            r_is_write <= cpu_wren;
                            r_starve   <= 8'd0;
                            if (cpu_wren) begin
                                mem_wdata <= cpu_wdata;
                            end
                        end else begin
                            mem_addr   <= vga_addr;
                            mem_wren   <= 1'b0;
                            r_is_write <= 1'b0;
                            if (cpu_req && !w_starved) begin
                                r_starve <= r_starve + 8'd1;
                            end
                        end
                    end
                end
                c_ISSUE: begin
                    mem_wren <= 1'b0;
                    r_state  <= c_WAIT;
                end
                c_WAIT: begin
                    // mem_rdata now holds the word sampled at the ISSUE->WAIT edge
                    r_state <= c_RESP;
                    if (r_owner_cpu) begin
                        cpu_ready <= 1'b1;
                        if (!r_is_write) begin
                            cpu_rdata <= mem_rdata;
                        end
                    end else begin
                        vga_valid <= 1'b1;
                        vga_data  <= w_byte;
                    end
                end
                c_RESP: begin
                    vga_valid <= 1'b0;
                    cpu_ready <= 1'b0;
                    r_state   <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width of all address ports.
REQ-002 Parameter: DATA_W, 32, memory word width.
REQ-003 Parameter: STARVE_LIMIT, 8, max consecutive VGA grants while cpu_req is pending; legal range 1..255.
REQ-004 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 Port: vga_req  in  1  VGA read request; held high with stable vga_addr until vga_valid.
REQ-007 Port: vga_addr  in  ADDR_W  VGA byte address.
REQ-008 Port: vga_data  out  8  VGA read byte; meaningful only while vga_valid=1.
REQ-009 Port: vga_valid  out  1  one-cycle VGA response pulse.
REQ-010 Port: cpu_req  in  1  CPU request; held high with stable cpu_addr, cpu_wren and cpu_wdata until cpu_ready.
REQ-011 Port: cpu_wren  in  1  1 = write, 0 = read.
REQ-012 Port: cpu_addr  in  ADDR_W  CPU word address.
REQ-013 Port: cpu_wdata  in  DATA_W  CPU write data.
REQ-014 Port: cpu_rdata  out  DATA_W  CPU read data; updated only on CPU read completion.
REQ-015 Port: cpu_ready  out  1  one-cycle CPU completion pulse, for reads and writes.
REQ-016 Port: mem_addr  out  ADDR_W  registered address to the single-port synchronous memory.
REQ-017 Port: mem_wren  out  1  registered memory write enable.
REQ-018 Port: mem_wdata  out  DATA_W  registered memory write data.
REQ-019 Port: mem_rdata  in  DATA_W  memory read word; valid one cycle after the memory samples mem_addr.

Function
REQ-020 The block SHALL implement FSM states IDLE, ISSUE, WAIT and RESP, one access at a time.
REQ-021 IDLE, no request pending: the FSM SHALL remain in IDLE with mem_wren=0.
REQ-022 IDLE, any request pending: the FSM SHALL select a winner (REQ-026..028), register the winner's address (and, for a CPU write, mem_wren=1 and wdata) into the mem_* outputs, latch the owner and vga_addr[1:0], and go to ISSUE.
REQ-023 ISSUE -> WAIT unconditionally; mem_wren SHALL be 1 during ISSUE only, and only for a CPU write.
REQ-024 WAIT -> RESP unconditionally; at this edge the block SHALL capture mem_rdata for reads.
REQ-025 RESP: exactly one of vga_valid or cpu_ready SHALL be 1 for this single cycle, according to the latched owner; next state IDLE.
REQ-026 Priority: VGA SHALL win when both requests are pending, unless the starvation count equals STARVE_LIMIT.
REQ-027 Starvation count: 8-bit; SHALL increment on each VGA grant made while cpu_req=1; SHALL clear on a CPU grant or in any IDLE cycle with cpu_req=0; SHALL saturate at STARVE_LIMIT.
REQ-028 When the starvation count equals STARVE_LIMIT and cpu_req=1, the CPU SHALL win the next arbitration.
REQ-029 vga_data SHALL be the byte of the captured word selected by latched vga_addr[1:0]: 0 -> [7:0], 1 -> [15:8], 2 -> [23:16], 3 -> [31:24].
REQ-030 Latency SHALL be 3 cycles from IDLE grant edge to response pulse; one access completes every 4 cycles.
REQ-031 A request still high in the IDLE cycle following its RESP SHALL be treated as a new request.
REQ-032 Requests arriving in ISSUE, WAIT or RESP SHALL be ignored until IDLE; requests SHALL never be lost or queued beyond the held req level.
REQ-033 cpu_rdata SHALL hold its value across VGA accesses and CPU writes.

Reset
REQ-034 While reset=0: FSM in IDLE; starvation count 0; mem_addr, mem_wdata, cpu_rdata, vga_data all 0; mem_wren, vga_valid, cpu_ready all 0.
REQ-035 Reset asserted mid-access SHALL abandon the access with no response pulse; a write in ISSUE SHALL have mem_wren forced to 0 immediately.
REQ-036 After reset deasserts, arbitration SHALL start at the first rising edge with reset=1.

Verification
REQ-037 Scenario: CPU write addr 0x10, data 0xDEADBEEF, then CPU read 0x10 -> mem_wren=1 for exactly one cycle; read cpu_ready at latency 3 with cpu_rdata=0xDEADBEEF.
REQ-038 Scenario: VGA reads vga_addr 0x21, 0x22, 0x23 with memory word 0x44332211 -> vga_data = 0x22, 0x33, 0x44 respectively.
REQ-039 Scenario: vga_req and cpu_req asserted in the same cycle -> VGA granted first, CPU granted next (cpu_ready 4 cycles after vga_valid).
REQ-040 Scenario: vga_req held continuously with cpu_req=1, STARVE_LIMIT=8 -> exactly 8 vga_valid pulses, then one cpu_ready, then VGA resumes.
REQ-041 Scenario: reset pulled low during ISSUE of a CPU write -> mem_wren=0 immediately, no cpu_ready; all outputs 0; a clean access completes after release.
REQ-042 Scenario: no requests for 20 cycles -> mem_wren, vga_valid and cpu_ready stay 0; starvation count stays 0.
